bus_slice_assembler: RTL
========================

Name: bus_slice_assembler

Overview:
- Collects bit-slice writes (msb, lsb, data) that arrive in any order and assembles them into one full-width bus word.
- Emits the word on a valid/ready output once every bit has been written exactly once.
- Sits upstream of the bus-consuming sink: it produces the complete source bus that the downstream per-bit and per-range assigns distribute.

Parameters:
- WIDTH, 4, bus width in bits (>=2).
- IDX_W, $clog2(WIDTH), index width for msb/lsb. Derived; not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard any partial or held word.
- in_valid  input  1  slice write request.
- in_ready  output  1  block can accept a slice.
- in_msb  input  IDX_W  slice upper bit index.
- in_lsb  input  IDX_W  slice lower bit index.
- in_data  input  WIDTH  slice value, right-aligned; bits above (msb-lsb) ignored.
- out_valid  output  1  assembled word available.
- out_ready  input  1  consumer accepts word.
- out_bus  output  WIDTH  assembled word.
- err_range  output  1  one-cycle pulse: illegal slice rejected.
- err_overlap  output  1  one-cycle pulse: slice hit already-written bits, rejected.

Behaviour:
- Reset: one clock, synchronous, active-high; rst sampled on clk rising edge. Sets state=COLLECT, coverage mask cov=0, data buffer buf=0, out_valid=0, out_bus=0, err_range=0, err_overlap=0. in_ready=1 from the first cycle after reset. rst overrides all other inputs, including mid-collection or mid-hold.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1, out_bus=buf stable.
- Accept condition: in_valid && in_ready.
- Range check: illegal if in_msb<in_lsb or in_msb>=WIDTH.
  - Slice discarded; err_range=1 on the next cycle only.
  - cov and buf unchanged.
- Slice mask: mask = ones over bits [in_msb:in_lsb].
- Overlap check: if range is legal and (mask & cov)!=0, the whole slice is discarded (no partial write). err_overlap=1 on the next cycle only.
- Legal, non-overlapping slice:
  - buf <= (buf & ~mask) | ((in_data << in_lsb) & mask).
  - cov <= cov | mask.
- Completion: if the updated cov is all ones, state=HOLD on the next cycle. Latency: last slice accepted in cycle N -> out_valid=1 in cycle N+1. A single full-width slice [WIDTH-1:0] completes in one accept.
- Output handshake: in HOLD, when out_valid && out_ready, then next cycle:
  - state=COLLECT, cov=0, out_valid=0, in_ready=1.
  - buf retains its old value but is don't-care until the next completion.
- out_bus: registered, equals buf while in HOLD, 0 otherwise.
- While out_valid=1 and out_ready=0, out_bus must not change.
- Back-to-back words: minimum one idle cycle. The slot is freed in the cycle after the out handshake, so the earliest next accept is cycle N+2 after the handshake in cycle N+1.
- flush:
  - Any state: next cycle cov=0, state=COLLECT, out_valid=0.
  - flush has priority over a same-cycle accept: that slice is dropped with no error pulse.
  - flush has priority over a same-cycle out handshake: the word counts as dropped.
- Error pulses never assert in HOLD, because no accepts happen there.
- err_range and err_overlap are mutually exclusive; range is checked first.

Test Plan:
- WIDTH=4, after reset: send [3]=1, then [2:1]=2'b10, then [0]=1 (shuffled order), out_ready=1 -> out_valid=1 exactly one cycle after the third accept; out_bus=4'b1101; in_ready=1 again two cycles later.
- Send [3:0]=4'hA with out_ready=0 for 5 cycles, then 1 -> out_valid held high, out_bus=4'hA stable, in_ready=0 throughout; handshake then returns to COLLECT.
- Send [2:1]=2'b11, then [1]=0 -> err_overlap pulses for one cycle; then send [3]=0, [0]=0 -> out_bus=4'b0110, with bit1 unchanged by the rejected write.
- Send msb=1, lsb=2 -> err_range pulse, cov unchanged. Then send [3:0]=4'h5 -> out_bus=4'h5, proving no state leaked.
- Send [3:2]=2'b11, then assert flush together with in_valid on [1:0]=2'b00 -> no error pulse, no out_valid. Then send [3:0]=4'h3 -> out_bus=4'h3.
- Assert rst in HOLD with out_bus=4'hF -> next cycle out_valid=0, out_bus=0, in_ready=1. Assert rst mid-collection after [0] -> a subsequent [3:1] alone does not complete.

Source files
------------

// File: rtl/bus_slice_assembler.sv
// rtl/bus_slice_assembler.sv - assembles out-of-order bit-slice writes into a full bus word
module bus_slice_assembler #(
    parameter int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_msb,
    input  logic [IDX_W-1:0] in_lsb,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bus,
    output logic             err_range,
    output logic             err_overlap
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cov_q, cov_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] out_bus_q, out_bus_d;
    logic             err_range_q, err_range_d;
    logic             err_overlap_q, err_overlap_d;

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] new_buf;
    logic [WIDTH-1:0] new_cov;
    logic             range_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= COLLECT;
            cov_q         <= '0;
            buf_q         <= '0;
            out_bus_q     <= '0;
            err_range_q   <= 1'b0;
            err_overlap_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cov_q         <= cov_d;
            buf_q         <= buf_d;
            out_bus_q     <= out_bus_d;
            err_range_q   <= err_range_d;
            err_overlap_q <= err_overlap_d;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (i >= int'(in_lsb)) && (i <= int'(in_msb));
        end
        range_bad = (in_msb < in_lsb) || (32'(in_msb) >= WIDTH);
        new_buf   = (buf_q & ~mask) | ((in_data << in_lsb) & mask);
        new_cov   = cov_q | mask;

        state_d       = state_q;
        cov_d         = cov_q;
        buf_d         = buf_q;
        out_bus_d     = out_bus_q;
        err_range_d   = 1'b0;
        err_overlap_d = 1'b0;

        // flush wins over both a same-cycle accept and a same-cycle output handshake
        if (flush) begin
            state_d   = COLLECT;
            cov_d     = '0;
            out_bus_d = '0;
        end else if (state_q == COLLECT) begin
            if (in_valid) begin
                if (range_bad) begin
                    err_range_d = 1'b1;
                end else if ((mask & cov_q) != '0) begin
                    err_overlap_d = 1'b1;
                end else begin
                    buf_d = new_buf;
                    cov_d = new_cov;
                    if (&new_cov) begin
                        state_d   = HOLD;
                        out_bus_d = new_buf;
                    end
                end
            end
        end else if (out_ready) begin
            state_d   = COLLECT;
            cov_d     = '0;
            out_bus_d = '0;
        end
    end

    assign in_ready    = (state_q == COLLECT);
    assign out_valid   = (state_q == HOLD);
    assign out_bus     = out_bus_q;
    assign err_range   = err_range_q;
    assign err_overlap = err_overlap_q;

endmodule
